bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the 7-segment digit scanner. It takes a 14-bit binary value from the CPU/IO side and produces four packed BCD digits plus a leading-zero blank mask, which the scanner multiplexes onto the display. It uses a shift-and-add-3 (double-dabble) datapath, one bit per clock, so it needs no divider.

---
 rtl/bin2bcd_seq.sv | 114 +++++++++++
 tb/tb_bin2bcd_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// saturation at MAX_VAL and a leading-zero blank mask for the digit scanner.
//   state    | meaning
//   S_IDLE   | waiting for start; outputs hold last result
//   S_SHIFT  | add-3 then shift, one input bit per clock
//   S_FINISH | publish accumulator, blank mask and overflow
module bin2bcd_seq #(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4,
  parameter int MAX_VAL  = 9999
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [IN_WIDTH-1:0] MAX_BIN   = IN_WIDTH'(MAX_VAL);
  localparam logic [CW-1:0]       LAST_CNT  = CW'(IN_WIDTH - 1);
  localparam logic [DIGITS-1:0]   BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IN_WIDTH-1:0] r_bin;
  logic [BW-1:0]       r_acc;
  logic [CW-1:0]       r_count;
  logic                r_ovf;
  logic [BW-1:0]       w_acc_adj;
  logic [DIGITS-1:0]   w_blank;
  logic                w_last;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SHIFT;
      S_SHIFT:  if (w_last) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state != S_IDLE);
    w_last = (r_state == S_SHIFT) && (r_count == LAST_CNT);
  end

  // Correct every nibble before the shift so it stays a valid BCD digit.
  always_comb begin
    w_acc_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      else                         w_acc_adj[4*d +: 4] = r_acc[4*d +: 4];
    end
  end

  always_comb begin
    w_blank = '0;
    w_blank[DIGITS-1] = (r_acc[BW-1 -: 4] == 4'd0);
    for (int d = DIGITS - 2; d >= 1; d--) begin
      w_blank[d] = w_blank[d+1] && (r_acc[4*d +: 4] == 4'd0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bin    <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      bcd      <= '0;
      blank    <= BLANK_RST;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin   <= (bin > MAX_BIN) ? MAX_BIN : bin;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= (bin > MAX_BIN);
          end
        end
        S_SHIFT: begin
          {r_acc, r_bin} <= {w_acc_adj[BW-2:0], r_bin, 1'b0};
          r_count        <= r_count + CW'(1);
        end
        S_FINISH: begin
          bcd      <= r_acc;
          blank    <= w_blank;
          overflow <= r_ovf;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: table vectors plus corner sequences; expected results
// are queued when a start is driven and compared when done pulses.
module tb_bin2bcd_seq;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic        overflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   push_cnt = 0;
  vec_t exp_q[$];
  vec_t vecs[10];

  bin2bcd_seq dut (
    .clock(clock), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference via decimal arithmetic, independent of the shift-add datapath.
  function automatic vec_t model(input int v);
    vec_t r;
    int   s;
    s = (v > 9999) ? 9999 : v;
    r.bin   = 14'(v);
    r.bcd   = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    r.blank = {s < 1000, s < 100, s < 10, 1'b0};
    r.ovf   = (v > 9999);
    return r;
  endfunction

  always @(negedge clock) begin
    if (!reset && done) begin
      done_cnt++;
      chk("done_has_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        vec_t e;
        e = exp_q.pop_front();
        chk($sformatf("bcd_%0d", e.bin), 32'(bcd), 32'(e.bcd));
        chk($sformatf("blank_%0d", e.bin), 32'(blank), 32'(e.blank));
        chk($sformatf("ovf_%0d", e.bin), 32'(overflow), 32'(e.ovf));
        for (int d = 0; d < 4; d++)
          chk("nibble_range", 32'(bcd[4*d +: 4] <= 4'd9), 32'd1);
      end
    end
  end

  // Drive start at the current negedge and wait for done; returns in the done cycle.
  task automatic convert(input vec_t e);
    int   k;
    logic busy_ok;
    exp_q.push_back(e);
    push_cnt++;
    start   = 1'b1;
    bin     = e.bin;
    busy_ok = 1'b1;
    k       = 0;
    do begin
      @(negedge clock);
      k++;
      start = 1'b0;
      if (!done && busy !== 1'b1) busy_ok = 1'b0;
    end while (!done && k < 40);
    chk($sformatf("latency_%0d", e.bin), 32'(k - 1), 32'd15);
    chk("busy_window", 32'(busy_ok), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd), 32'h0000);
    chk({tag, "_blank"}, 32'(blank), 32'hE);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int snap;

    vecs[0] = '{14'd4564,  16'h4564, 4'b0000, 1'b0};
    vecs[1] = '{14'd3566,  16'h3566, 4'b0000, 1'b0};
    vecs[2] = '{14'd7432,  16'h7432, 4'b0000, 1'b0};
    vecs[3] = '{14'd609,   16'h0609, 4'b1000, 1'b0};
    vecs[4] = '{14'd54,    16'h0054, 4'b1100, 1'b0};
    vecs[5] = '{14'd8,     16'h0008, 4'b1110, 1'b0};
    vecs[6] = '{14'd9999,  16'h9999, 4'b0000, 1'b0};
    vecs[7] = '{14'd12000, 16'h9999, 4'b0000, 1'b1};
    vecs[8] = '{14'd16383, 16'h9999, 4'b0000, 1'b1};
    vecs[9] = '{14'd10,    16'h0010, 4'b1100, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(negedge clock);
    check_idle_reset("reset");
    reset = 1'b0;
    @(negedge clock);

    convert(model(0));

    // Back-to-back: each convert returns in the done cycle and restarts there.
    for (int i = 0; i < 10; i++) convert(vecs[i]);
    @(negedge clock);

    // Start while busy is ignored; bin changes mid-conversion have no effect.
    snap = done_cnt;
    exp_q.push_back(model(232));
    push_cnt++;
    start = 1'b1;
    bin   = 14'd232;
    k     = 0;
    do begin
      @(negedge clock);
      k++;
      start = 1'b0;
      if (k == 5) begin start = 1'b1; bin = 14'd93; end
      if (k == 8) bin = 14'd7777;
    end while (!done && k < 40);
    chk("ignore_latency", 32'(k - 1), 32'd15);
    chk("ignore_bcd", 32'(bcd), 32'h0232);
    repeat (20) @(negedge clock);
    chk("ignore_one_done", 32'(done_cnt - snap), 32'd1);
    chk("ignore_idle", 32'(busy), 32'd0);

    // Reset mid-conversion aborts with no done pulse.
    convert(model(4564));
    start = 1'b1;
    bin   = 14'd1234;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle_reset("abort");
    snap = done_cnt;
    repeat (20) @(negedge clock);
    chk("abort_no_done", 32'(done_cnt - snap), 32'd0);
    convert(model(1234));
    @(negedge clock);

    // Sampled sweep: low values, around saturation, top of range, random.
    for (int v = 0; v <= 120; v++) convert(model(v));
    for (int v = 9980; v <= 10020; v++) convert(model(v));
    for (int v = 16370; v <= 16383; v++) convert(model(v));
    for (int i = 0; i < 800; i++) convert(model(int'($urandom_range(16383, 0))));
    repeat (3) @(negedge clock);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(push_cnt));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
